tick_timer: RTL and testbench
=============================

// Module: tick_timer
// PURPOSE
//  Programmable delay/timeout timer that consumes the 1us/1ms strobes (us_tck,
//  ms_tck) from the clock generation module. Control FSMs (camera power-up,
//  I2C config waits, memory init) load a count and a unit, then wait for done.
//  Supports one-shot and periodic (auto-reload) operation; runs in the
//  pll_outclk_0 domain, the same domain as the strobes.
// PARAMETERS
//  CNT_W   16  width of load/remaining count (max delay 2^CNT_W-1 units)
// PORTS
//  clk        in   1      pll_outclk_0 domain clock
//  rst        in   1      async active-low reset (0 = reset)
//  us_tck     in   1      1-cycle strobe, one per ~1us
//  ms_tck     in   1      1-cycle strobe, one per 1ms
//  start      in   1      request: load and run timer (accepted only when !busy)
//  unit       in   1      0 = count us_tck, 1 = count ms_tck (sampled at start)
//  repeat_en  in   1      1 = auto-reload after expiry (sampled at start)
//  load       in   CNT_W  delay in units (sampled at start)
//  abort      in   1      stop timer, return to IDLE, no done pulse
//  busy       out  1      timer armed (SYNC or COUNT)
//  done       out  1      1-cycle pulse on each expiry
//  expired    out  1      level: set on one-shot expiry, cleared by start/abort
//  remaining  out  CNT_W  units left in current period
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset: state=IDLE; busy=0, done=0, expired=0, remaining=0; latched
//    unit/repeat/load=0. Reset mid-count discards everything, no done pulse.
//  - Selected tick: tck = unit_q ? ms_tck : us_tck; the other strobe is ignored.
//  - FSM IDLE/SYNC/COUNT/DONE; all outputs registered.
//  - IDLE or DONE, start=1, abort=0: latch unit/repeat_en/load, remaining<=load,
//    expired<=0, go to SYNC (busy=1 from next cycle). A tick in the start cycle
//    is ignored.
//  - load==0 at start: skip counting; done pulses 1 cycle after start;
//    one-shot -> DONE with expired=1; repeat_en with load==0 is treated as
//    one-shot.
//  - SYNC: wait for first tck (discarded, aligns to unit boundary) -> COUNT.
//    Guaranteed delay: N units <= t <= N units + 1 tick period.
//  - COUNT: each tck decrements remaining. On tck with remaining==1: done=1
//    for that next cycle, remaining<=0. One-shot -> DONE, expired=1, busy=0.
//    Repeat -> remaining<=load_q, stay COUNT; period is exactly N ticks.
//  - DONE: holds expired=1 until start/abort; behaves as IDLE for start.
//  - start while busy is ignored (no restart, no error).
//  - abort (any state) -> IDLE next cycle; busy=0, expired=0, remaining=0,
//    no done. abort wins over same-cycle start and same-cycle terminal tck.
//  - remaining never wraps: no decrement at 0.
// STRUCTURE
//  - Shared package/include (clocks_pkg): state encodings (IDLE=0, SYNC=1,
//    COUNT=2, DONE=3), UNIT_US=1'b0, UNIT_MS=1'b1 for all timer users.
//  - Single module; no sub-module needed (tick mux + down-counter + FSM).
// TESTING (bench drives us_tck every 26 clk, ms_tck every 1000 clk)
//  - unit=0, load=5, one-shot: done once, 131..156 clk after start;
//    expired=1 afterward; busy=0.
//  - unit=1, load=3, repeat_en=1: done every 3000 clk exactly after the
//    first; remaining cycles 3,2,1 and reloads to 3; busy stays 1.
//  - load=0: done exactly 1 clk after start, no SYNC, expired=1.
//  - abort at remaining=2 and abort coincident with the terminal tick:
//    no done pulse, IDLE, expired=0; a start in the same cycle as abort
//    is dropped.
//  - start while busy (different load) ignored; rst=0 mid-COUNT gives all
//    outputs 0 asynchronously, and the next start works normally.
//  - us_tck and ms_tck coincident with unit=1: only ms counted; the
//    remaining decrement matches the ms count.

Source files
------------

// File: rtl/clocks_pkg.sv
// Shared encodings for users of the 1us/1ms strobes.
package clocks_pkg;

    // Timer FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } tmr_state_t;

    // Timer unit select
    localparam logic UNIT_US = 1'b0;
    localparam logic UNIT_MS = 1'b1;

    // Default width of the timer load/remaining count
    localparam int unsigned TMR_CNT_W = 16;

endpackage

// File: rtl/tick_timer.sv
// Programmable delay/timeout timer driven by the 1us/1ms strobes.
// A control FSM loads a count and a unit, then waits for done. One-shot and
// periodic (auto-reload) operation are supported.
// Ports:
//   clk        clock (same domain as the strobes)
//   rst        async active-low reset
//   us_tck     1-cycle strobe per ~1us
//   ms_tck     1-cycle strobe per 1ms
//   start      load and run (accepted only when not busy)
//   unit       0 = count us_tck, 1 = count ms_tck (sampled at start)
//   repeat_en  auto-reload after expiry (sampled at start)
//   load       delay in units (sampled at start)
//   abort      stop, return to idle, no done pulse
//   busy       timer armed (SYNC or COUNT)
//   done       1-cycle pulse on each expiry
//   expired    set on one-shot expiry, cleared by start/abort
//   remaining  units left in current period
module tick_timer
    import clocks_pkg::*;
#(
    parameter int unsigned CNT_W = TMR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             us_tck,
    input  logic             ms_tck,
    input  logic             start,
    input  logic             unit,
    input  logic             repeat_en,
    input  logic [CNT_W-1:0] load,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output logic [CNT_W-1:0] remaining
);

    tmr_state_t       state;
    logic             unit_q;
    logic             repeat_q;
    logic [CNT_W-1:0] load_q;
    logic             tck_c;

    // Only the strobe of the latched unit is counted
    assign tck_c = (unit_q == UNIT_MS) ? ms_tck : us_tck;

    // Timer FSM, down-counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            unit_q    <= UNIT_US;
            repeat_q  <= 1'b0;
            load_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            expired   <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // abort overrides any same-cycle start or terminal tick
                state     <= ST_IDLE;
                busy      <= 1'b0;
                expired   <= 1'b0;
                remaining <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            unit_q    <= unit;
                            repeat_q  <= repeat_en;
                            load_q    <= load;
                            remaining <= load;
                            expired   <= 1'b0;
                            if (load == '0) begin
                                // zero delay: expire immediately, never periodic
                                done    <= 1'b1;
                                expired <= 1'b1;
                                busy    <= 1'b0;
                                state   <= ST_DONE;
                            end else begin
                                busy  <= 1'b1;
                                state <= ST_SYNC;
                            end
                        end
                    end
                    ST_SYNC: begin
                        // first tick only aligns to a unit boundary
                        if (tck_c) begin
                            state <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (tck_c) begin
                            if (remaining == CNT_W'(1)) begin
                                done <= 1'b1;
                                if (repeat_q) begin
                                    remaining <= load_q;
                                end else begin
                                    remaining <= '0;
                                    expired   <= 1'b1;
                                    busy      <= 1'b0;
                                    state     <= ST_DONE;
                                end
                            end else if (remaining != '0) begin
                                remaining <= remaining - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: table of short manually-ticked cases
// plus hand-written long-running sequences with free-running strobes.
module tb_tick_timer;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             us_tck;
    logic             ms_tck;
    logic             start;
    logic             unit;
    logic             repeat_en;
    logic [CNT_W-1:0] load;
    logic             abort;
    logic             busy;
    logic             done;
    logic             expired;
    logic [CNT_W-1:0] remaining;

    logic gen_en;
    logic gen_us;
    logic gen_ms;
    logic man_us;
    logic man_ms;
    int   cyc;
    int   done_total;
    int   errors;
    int   checks;

    typedef struct {
        logic unit;
        logic rep;
        int   load;
        int   n_sel;
        int   n_oth;
        int   n_both;
        int   e_done;
        int   e_rem;
        logic e_busy;
        logic e_exp;
    } vec_t;

    typedef struct {
        int   done_cnt;
        int   rem;
        logic busy;
        logic exp;
    } exp_t;

    exp_t sb[$];
    vec_t vt[11];

    tick_timer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .us_tck    (us_tck),
        .ms_tck    (ms_tck),
        .start     (start),
        .unit      (unit),
        .repeat_en (repeat_en),
        .load      (load),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .expired   (expired),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign us_tck = gen_en ? gen_us : man_us;
    assign ms_tck = gen_en ? gen_ms : man_ms;

    // Free-running strobes: us every 26 clk, ms every 1000 clk
    always @(negedge clk) begin
        if (gen_en) begin
            cyc    = cyc + 1;
            gen_us = (cyc % 26 == 0);
            gen_ms = (cyc % 1000 == 0);
        end else begin
            gen_us = 1'b0;
            gen_ms = 1'b0;
        end
    end

    // Count every done pulse seen
    always @(negedge clk) begin
        if (done === 1'b1) done_total = done_total + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_start(input logic u, input logic r, input int l);
        @(negedge clk);
        unit      = u;
        repeat_en = r;
        load      = CNT_W'(l);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic pulse(input logic u, input logic m);
        @(negedge clk);
        man_us = u;
        man_ms = m;
        @(negedge clk);
        man_us = 1'b0;
        man_ms = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int   n;
        int   base;
        exp_t e;
        logic busy_dropped;

        errors     = 0;
        checks     = 0;
        done_total = 0;
        cyc        = 0;
        gen_en     = 1'b0;
        gen_us     = 1'b0;
        gen_ms     = 1'b0;
        man_us     = 1'b0;
        man_ms     = 1'b0;
        start      = 1'b0;
        unit       = 1'b0;
        repeat_en  = 1'b0;
        load       = '0;
        abort      = 1'b0;
        rst        = 1'b0;

        // Reset state
        wait_cycles(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_expired", int'(expired), 0);
        chk("rst_remaining", int'(remaining), 0);
        rst = 1'b1;
        wait_cycles(2);

        // unit rep load sel oth both | done rem busy exp
        vt[0]  = '{1'b0, 1'b0, 4,     2, 3, 0, 0, 3,     1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 4,     3, 5, 0, 0, 2,     1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 2,     3, 0, 0, 1, 0,     1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 2,     5, 0, 0, 1, 0,     1'b0, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 2,     3, 0, 0, 1, 2,     1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 2,     5, 0, 0, 2, 2,     1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 0,     0, 0, 0, 1, 0,     1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 0,     3, 0, 0, 1, 0,     1'b0, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 65535, 2, 0, 0, 0, 65534, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 3,     0, 4, 3, 0, 1,     1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1,     1, 2, 0, 0, 1,     1'b1, 1'b0};

        for (int v = 0; v < 11; v++) begin
            do_abort();
            base = done_total;
            do_start(vt[v].unit, vt[v].rep, vt[v].load);
            sb.push_back('{vt[v].e_done, vt[v].e_rem, vt[v].e_busy, vt[v].e_exp});
            for (int i = 0; i < vt[v].n_sel; i++) pulse(!vt[v].unit, vt[v].unit);
            for (int i = 0; i < vt[v].n_oth; i++) pulse(vt[v].unit, !vt[v].unit);
            for (int i = 0; i < vt[v].n_both; i++) pulse(1'b1, 1'b1);
            wait_cycles(2);
            e = sb.pop_front();
            chk($sformatf("vec%0d_done_cnt", v), done_total - base, e.done_cnt);
            chk($sformatf("vec%0d_remaining", v), int'(remaining), e.rem);
            chk($sformatf("vec%0d_busy", v), int'(busy), int'(e.busy));
            chk($sformatf("vec%0d_expired", v), int'(expired), int'(e.exp));
        end

        // Abort coincident with the terminal tick
        do_abort();
        base = done_total;
        do_start(1'b0, 1'b0, 1);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        man_us = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        man_us = 1'b0;
        abort  = 1'b0;
        chk("abort_term_done", int'(done), 0);
        chk("abort_term_busy", int'(busy), 0);
        chk("abort_term_expired", int'(expired), 0);
        wait_cycles(3);
        chk("abort_term_no_done", done_total - base, 0);

        // One-shot us delay latency with free-running strobes
        gen_en = 1'b1;
        wait_cycles(7);
        base = done_total;
        do_start(1'b0, 1'b0, 5);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_rng("oneshot_latency", n, 131, 156);
        wait_cycles(200);
        chk("oneshot_done_once", done_total - base, 1);
        chk("oneshot_expired", int'(expired), 1);
        chk("oneshot_busy", int'(busy), 0);

        // Periodic ms timer, with an ignored start while busy
        do_start(1'b1, 1'b1, 3);
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rep_first_done", int'(done), 1);
        chk("rep_reload_rem", int'(remaining), 3);
        busy_dropped = 1'b0;
        for (int p = 0; p < 2; p++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (p == 0 && n == 700) begin
                    load  = CNT_W'(7);
                    start = 1'b1;
                end
                if (n == 701) start = 1'b0;
                if (busy !== 1'b1) busy_dropped = 1'b1;
                if (n == 500)  chk($sformatf("rep%0d_rem3", p), int'(remaining), 3);
                if (n == 1500) chk($sformatf("rep%0d_rem2", p), int'(remaining), 2);
                if (n == 2500) chk($sformatf("rep%0d_rem1", p), int'(remaining), 1);
            end while (done !== 1'b1 && n < 4000);
            chk($sformatf("rep%0d_period", p), n, 3000);
            chk($sformatf("rep%0d_reload", p), int'(remaining), 3);
        end
        chk("rep_busy_held", int'(busy_dropped), 0);

        // Abort at remaining==2 together with a start that must be dropped
        n = 0;
        while (remaining != CNT_W'(2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_rem2_reached", int'(remaining), 2);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        load  = CNT_W'(9);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        base  = done_total;
        chk("abort_rem2_busy", int'(busy), 0);
        chk("abort_rem2_expired", int'(expired), 0);
        chk("abort_rem2_remaining", int'(remaining), 0);
        wait_cycles(3500);
        chk("abort_rem2_no_done", done_total - base, 0);
        chk("abort_start_dropped", int'(busy), 0);

        // Asynchronous reset mid-count, then normal restart
        do_start(1'b1, 1'b0, 3);
        wait_cycles(1500);
        chk("pre_rst_busy", int'(busy), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_expired", int'(expired), 0);
        chk("async_rst_remaining", int'(remaining), 0);
        @(negedge clk);
        rst = 1'b1;
        do_start(1'b0, 1'b0, 0);
        chk("post_rst_load0_done", int'(done), 1);
        chk("post_rst_load0_expired", int'(expired), 1);
        chk("post_rst_load0_busy", int'(busy), 0);
        @(negedge clk);
        chk("post_rst_load0_done_pulse", int'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
